// File: rtl/collision_pkg.sv
// Shared types, T-rex sub-box tables and the strict box-overlap rule for the collision checker.
package collision_pkg;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] width;
        logic [9:0] height;
    } collision_box_t;

    // Absolute box, every field carried as a 12-bit two's-complement value.
    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] width;
        logic [11:0] height;
    } abs_box_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COARSE = 2'd1,
        ST_FINE   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int TREX_BOX_COUNT = 6;
    localparam int OBS_BOX_COUNT  = 5;

    localparam collision_box_t TREX_RUNNING_BOXES [TREX_BOX_COUNT] = '{
        '{x: 10'd22, y: 10'd0,  width: 10'd17, height: 10'd16},
        '{x: 10'd1,  y: 10'd18, width: 10'd30, height: 10'd9},
        '{x: 10'd10, y: 10'd35, width: 10'd14, height: 10'd8},
        '{x: 10'd1,  y: 10'd24, width: 10'd29, height: 10'd5},
        '{x: 10'd5,  y: 10'd30, width: 10'd21, height: 10'd4},
        '{x: 10'd9,  y: 10'd34, width: 10'd15, height: 10'd4}
    };

    // Ducking uses a single box; the zero-size padding entries are skipped as misses.
    localparam collision_box_t TREX_DUCKING_BOXES [TREX_BOX_COUNT] = '{
        '{x: 10'd1, y: 10'd18, width: 10'd55, height: 10'd25},
        '{x: 10'd0, y: 10'd0,  width: 10'd0,  height: 10'd0},
        '{x: 10'd0, y: 10'd0,  width: 10'd0,  height: 10'd0},
        '{x: 10'd0, y: 10'd0,  width: 10'd0,  height: 10'd0},
        '{x: 10'd0, y: 10'd0,  width: 10'd0,  height: 10'd0},
        '{x: 10'd0, y: 10'd0,  width: 10'd0,  height: 10'd0}
    };

    // Touching edges do not count as an overlap.
    function automatic logic boxes_overlap(input abs_box_t a, input abs_box_t b);
        logic [11:0] a_right;
        logic [11:0] a_bottom;
        logic [11:0] b_right;
        logic [11:0] b_bottom;
        a_right  = a.x + a.width;
        a_bottom = a.y + a.height;
        b_right  = b.x + b.width;
        b_bottom = b.y + b.height;
        return ($signed(a.x) < $signed(b_right))  && ($signed(a_right) > $signed(b.x)) &&
               ($signed(a.y) < $signed(b_bottom)) && ($signed(a_bottom) > $signed(b.y));
    endfunction

endpackage

// File: rtl/collision_checker_box_overlap.sv
// Combinational strict-overlap comparator shared by the coarse and fine passes.
module box_overlap
    import collision_pkg::*;
(
    input  abs_box_t a,
    input  abs_box_t b,
    output logic     hit
);

    assign hit = boxes_overlap(a, b);

endmodule

// File: rtl/collision_checker.sv
// Per-frame T-rex vs nearest-obstacle collision check: one coarse test, then one sub-box pair per cycle.
module collision_checker
    import collision_pkg::*;
#(
    parameter int TREX_BOXES = TREX_BOX_COUNT,
    parameter int OBS_BOXES  = OBS_BOX_COUNT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          check,
    input  logic                          clear,
    input  logic                          obstacle_valid,
    input  logic [9:0]                    trex_x_pos,
    input  logic [9:0]                    trex_y_pos,
    input  logic [9:0]                    trex_width,
    input  logic [9:0]                    trex_height,
    input  collision_box_t                trex_box [TREX_BOXES],
    input  logic signed [10:0]            obstacle_x_pos,
    input  logic [9:0]                    obstacle_y_pos,
    input  logic [9:0]                    obstacle_width,
    input  logic [9:0]                    obstacle_height,
    input  collision_box_t                obstacle_box [OBS_BOXES],
    output logic                          busy,
    output logic                          done,
    output logic                          crash,
    output logic [$clog2(TREX_BOXES)-1:0] hit_trex_idx,
    output logic [$clog2(OBS_BOXES)-1:0]  hit_obs_idx,
    output state_t                        state_dbg
);

    localparam int IW = $clog2(TREX_BOXES);
    localparam int JW = $clog2(OBS_BOXES);
    localparam logic [IW-1:0] I_LAST = IW'(TREX_BOXES - 1);
    localparam logic [JW-1:0] J_LAST = JW'(OBS_BOXES - 1);

    state_t         state_q, state_d;
    logic [9:0]     tx_q, ty_q, tw_q, th_q;
    logic [11:0]    ox_q;
    logic [9:0]     oy_q, ow_q, oh_q;
    collision_box_t tbox_q [TREX_BOXES];
    collision_box_t obox_q [OBS_BOXES];
    logic [IW-1:0]  i_q;
    logic [JW-1:0]  j_q;
    collision_box_t tsel, osel;
    abs_box_t       op_a, op_b;
    logic           snap, ovl, zero_size, pair_hit, last_pair, fine_hit;

    // Handshake: check is accepted only in IDLE; every accepted check ends with exactly one
    // single-cycle done; clear aborts an in-flight check with no done and wins over check.
    assign busy      = (state_q == ST_COARSE) || (state_q == ST_FINE);
    assign done      = (state_q == ST_DONE);
    assign state_dbg = state_q;

    assign tsel      = tbox_q[i_q];
    assign osel      = obox_q[j_q];
    assign zero_size = (tsel.width == 10'd0) || (tsel.height == 10'd0) ||
                       (osel.width == 10'd0) || (osel.height == 10'd0);
    assign pair_hit  = ovl && !zero_size;
    assign last_pair = (i_q == I_LAST) && (j_q == J_LAST);

    // Coarse pass shrinks the T-rex by one pixel per side; fine pass uses absolute sub-boxes.
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (state_q == ST_FINE) begin
            op_a.x      = {2'b00, tx_q} + {2'b00, tsel.x};
            op_a.y      = {2'b00, ty_q} + {2'b00, tsel.y};
            op_a.width  = {2'b00, tsel.width};
            op_a.height = {2'b00, tsel.height};
            op_b.x      = ox_q + {2'b00, osel.x};
            op_b.y      = {2'b00, oy_q} + {2'b00, osel.y};
            op_b.width  = {2'b00, osel.width};
            op_b.height = {2'b00, osel.height};
        end else begin
            op_a.x      = {2'b00, tx_q} + 12'd1;
            op_a.y      = {2'b00, ty_q} + 12'd1;
            op_a.width  = {2'b00, tw_q} - 12'd2;
            op_a.height = {2'b00, th_q} - 12'd2;
            op_b.x      = ox_q;
            op_b.y      = {2'b00, oy_q};
            op_b.width  = {2'b00, ow_q};
            op_b.height = {2'b00, oh_q};
        end
    end

    box_overlap u_overlap (
        .a   (op_a),
        .b   (op_b),
        .hit (ovl)
    );

    always_comb begin
        state_d  = state_q;
        snap     = 1'b0;
        fine_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (check) begin
                    if (obstacle_valid) begin
                        snap    = 1'b1;
                        state_d = ST_COARSE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_COARSE: state_d = ovl ? ST_FINE : ST_DONE;
            ST_FINE: begin
                if (pair_hit) begin
                    fine_hit = 1'b1;
                    state_d  = ST_DONE;
                end else if (last_pair) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d  = ST_IDLE;
            snap     = 1'b0;
            fine_hit = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pair counter walks j fastest, so (i, j) = (k / OBS_BOXES, k mod OBS_BOXES).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            j_q <= '0;
        end else if (state_q == ST_COARSE) begin
            i_q <= '0;
            j_q <= '0;
        end else if (state_q == ST_FINE) begin
            if (j_q == J_LAST) begin
                j_q <= '0;
                i_q <= i_q + 1'b1;
            end else begin
                j_q <= j_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crash        <= 1'b0;
            hit_trex_idx <= '0;
            hit_obs_idx  <= '0;
        end else if (clear) begin
            crash        <= 1'b0;
            hit_trex_idx <= '0;
            hit_obs_idx  <= '0;
        end else if (fine_hit) begin
            crash <= 1'b1;
            if (!crash) begin
                hit_trex_idx <= i_q;
                hit_obs_idx  <= j_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (snap) begin
            tx_q <= trex_x_pos;
            ty_q <= trex_y_pos;
            tw_q <= trex_width;
            th_q <= trex_height;
            ox_q <= {obstacle_x_pos[10], obstacle_x_pos};
            oy_q <= obstacle_y_pos;
            ow_q <= obstacle_width;
            oh_q <= obstacle_height;
            for (int t = 0; t < TREX_BOXES; t++) tbox_q[t] <= trex_box[t];
            for (int o = 0; o < OBS_BOXES; o++)  obox_q[o] <= obstacle_box[o];
        end
    end

endmodule

// File: tb/tb_collision_checker.sv
// Scoreboard bench for collision_checker: expected done cycle / crash / hit indices queued per check.
module tb_collision_checker;
    import collision_pkg::*;

    localparam int TB    = 6;
    localparam int OB    = 5;
    localparam int NPAIR = TB * OB;
    localparam int W     = 23;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                check = 1'b0;
    logic                clear = 1'b0;
    logic                obstacle_valid = 1'b1;
    logic [9:0]          trex_x_pos, trex_y_pos, trex_width, trex_height;
    collision_box_t      trex_box [TB];
    logic signed [10:0]  obstacle_x_pos;
    logic [9:0]          obstacle_y_pos, obstacle_width, obstacle_height;
    collision_box_t      obstacle_box [OB];
    logic                busy, done, crash;
    logic [2:0]          hit_trex_idx, hit_obs_idx;
    state_t              state_dbg;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    bit           m_crash = 1'b0;
    int           m_hi = 0;
    int           m_hj = 0;

    always #5 clk = ~clk;

    collision_checker dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .check           (check),
        .clear           (clear),
        .obstacle_valid  (obstacle_valid),
        .trex_x_pos      (trex_x_pos),
        .trex_y_pos      (trex_y_pos),
        .trex_width      (trex_width),
        .trex_height     (trex_height),
        .trex_box        (trex_box),
        .obstacle_x_pos  (obstacle_x_pos),
        .obstacle_y_pos  (obstacle_y_pos),
        .obstacle_width  (obstacle_width),
        .obstacle_height (obstacle_height),
        .obstacle_box    (obstacle_box),
        .busy            (busy),
        .done            (done),
        .crash           (crash),
        .hit_trex_idx    (hit_trex_idx),
        .hit_obs_idx     (hit_obs_idx),
        .state_dbg       (state_dbg)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Monitor: cycle n is the interval after edge n-1, sampled on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                if (done) begin
                    void'(exp_q.pop_front());
                    check_eq("done_cycle", cyc, 32'(e[22:7]));
                    check_eq("crash", crash, e[6]);
                    if (e[6]) begin
                        check_eq("hit_trex_idx", hit_trex_idx, e[5:3]);
                        check_eq("hit_obs_idx", hit_obs_idx, e[2:0]);
                    end
                    check_eq("busy_at_done", busy, 0);
                end else begin
                    check_eq("busy", busy, (cyc < int'(e[22:7])) ? 1 : 0);
                end
            end else if (done) begin
                check_eq("spurious_done", done, 0);
            end
        end
    end

    function automatic collision_box_t mk_box(input int x, input int y, input int w, input int h);
        collision_box_t b;
        b.x = 10'(x);
        b.y = 10'(y);
        b.width = 10'(w);
        b.height = 10'(h);
        return b;
    endfunction

    function automatic bit ov(input int ax, input int ay, input int aw, input int ah,
                              input int bx, input int by, input int bw, input int bh);
        return (ax < bx + bw) && (ax + aw > bx) && (ay < by + bh) && (ay + ah > by);
    endfunction

    task automatic model(output int lat, output bit hit, output int hi, output int hj);
        int tx, ty, ox, oy;
        hit = 1'b0;
        hi = 0;
        hj = 0;
        tx = int'(trex_x_pos);
        ty = int'(trex_y_pos);
        ox = int'(obstacle_x_pos);
        oy = int'(obstacle_y_pos);
        if (!obstacle_valid) begin
            lat = 1;
            return;
        end
        if (!ov(tx + 1, ty + 1, int'(trex_width) - 2, int'(trex_height) - 2,
                ox, oy, int'(obstacle_width), int'(obstacle_height))) begin
            lat = 2;
            return;
        end
        lat = 2 + NPAIR;
        for (int k = 0; k < NPAIR; k++) begin
            collision_box_t a, b;
            a = trex_box[k / OB];
            b = obstacle_box[k % OB];
            if (a.width == 0 || a.height == 0 || b.width == 0 || b.height == 0) continue;
            if (ov(tx + int'(a.x), ty + int'(a.y), int'(a.width), int'(a.height),
                   ox + int'(b.x), oy + int'(b.y), int'(b.width), int'(b.height))) begin
                lat = 3 + k;
                hit = 1'b1;
                hi = k / OB;
                hj = k % OB;
                return;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_check(input bit push, input int lat, input bit c, input int hi, input int hj);
        check = 1'b1;
        @(posedge clk);
        #1;
        check = 1'b0;
        if (push) exp_q.push_back({16'(cyc + lat), c, 3'(hi), 3'(hj)});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            check_eq("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        tick(2);
    endtask

    task automatic expect_start(input int lat, input bit hit, input int hi, input int hj);
        if (hit && !m_crash) begin
            m_hi = hi;
            m_hj = hj;
        end
        m_crash = m_crash | hit;
        start_check(1'b1, lat, m_crash, m_hi, m_hj);
    endtask

    task automatic run_check(input int lat, input bit hit, input int hi, input int hj);
        expect_start(lat, hit, hi, hj);
        wait_idle();
    endtask

    task automatic model_clear();
        m_crash = 1'b0;
        m_hi = 0;
        m_hj = 0;
    endtask

    task automatic set_obs(input int x, input int y, input int w, input int h);
        obstacle_x_pos  = 11'(x);
        obstacle_y_pos  = 10'(y);
        obstacle_width  = 10'(w);
        obstacle_height = 10'(h);
    endtask

    task automatic set_trex_default();
        trex_x_pos  = 10'd50;
        trex_y_pos  = 10'd93;
        trex_width  = 10'd44;
        trex_height = 10'd47;
        trex_box    = TREX_RUNNING_BOXES;
    endtask

    // Coarse overlap, every obstacle sub-box left of all T-rex sub-boxes.
    task automatic set_full_miss();
        set_trex_default();
        set_obs(40, 105, 20, 10);
        for (int o = 0; o < OB; o++) obstacle_box[o] = mk_box(0, 0, 2, 2);
    endtask

    task automatic randomize_geom();
        trex_x_pos  = 10'($urandom_range(20, 200));
        trex_y_pos  = 10'($urandom_range(40, 200));
        trex_width  = 10'($urandom_range(10, 60));
        trex_height = 10'($urandom_range(10, 60));
        for (int t = 0; t < TB; t++)
            trex_box[t] = mk_box($urandom_range(0, 40), $urandom_range(0, 40),
                                 $urandom_range(0, 15), $urandom_range(0, 15));
        set_obs(int'(trex_x_pos) + int'($urandom_range(0, 120)) - 60,
                int'(trex_y_pos) + int'($urandom_range(0, 60)) - 30,
                $urandom_range(5, 60), $urandom_range(5, 60));
        for (int o = 0; o < OB; o++)
            obstacle_box[o] = mk_box($urandom_range(0, 40), $urandom_range(0, 40),
                                     $urandom_range(0, 15), $urandom_range(0, 15));
        obstacle_valid = ($urandom_range(0, 9) != 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, hi, hj;
        bit hit;

        // Clock/reset
        set_full_miss();
        tick(3);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_crash", crash, 0);
        check_eq("rst_hit_trex_idx", hit_trex_idx, 0);
        check_eq("rst_hit_obs_idx", hit_obs_idx, 0);
        check_eq("rst_state", state_dbg, ST_IDLE);
        rst_n = 1'b1;
        tick(2);

        // Coarse miss far right
        set_trex_default();
        set_obs(600, 100, 25, 40);
        run_check(2, 1'b0, 0, 0);

        // Full fine scan, nothing hits
        set_full_miss();
        run_check(32, 1'b0, 0, 0);

        // Zero-width obstacle box that would otherwise overlap T-rex box 1
        set_full_miss();
        obstacle_box[0] = mk_box(15, 6, 0, 3);
        run_check(32, 1'b0, 0, 0);

        // Edge touch: obstacle box left edge at T-rex box 1 right edge (x=81)
        set_full_miss();
        obstacle_box[0] = mk_box(41, 6, 5, 3);
        run_check(32, 1'b0, 0, 0);

        // Negative x, right edge 5 left of shrunk T-rex at 51
        set_trex_default();
        set_obs(-20, 100, 25, 40);
        run_check(2, 1'b0, 0, 0);

        // No obstacle
        obstacle_valid = 1'b0;
        run_check(1, 1'b0, 0, 0);
        obstacle_valid = 1'b1;

        // check pulsed while busy is ignored
        set_full_miss();
        expect_start(32, 1'b0, 0, 0);
        tick(5);
        check = 1'b1;
        tick(1);
        check = 1'b0;
        wait_idle();
        tick(3);

        // Single hit on T-rex box 1 vs obstacle box 0 (k=5)
        set_full_miss();
        obstacle_box[0] = mk_box(15, 6, 5, 3);
        run_check(8, 1'b1, 1, 0);

        // Sticky crash survives a miss
        set_trex_default();
        set_obs(600, 100, 25, 40);
        run_check(2, 1'b0, 0, 0);

        // Later hit (k=6) does not overwrite the latched indices
        set_full_miss();
        obstacle_box[0] = mk_box(15, 6, 0, 3);
        obstacle_box[1] = mk_box(15, 6, 5, 3);
        run_check(9, 1'b1, 1, 1);

        // clear during cycle 10 of a fine scan
        set_full_miss();
        start_check(1'b0, 0, 1'b0, 0, 0);
        tick(9);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        model_clear();
        check_eq("clr_busy", busy, 0);
        check_eq("clr_done", done, 0);
        check_eq("clr_crash", crash, 0);
        check_eq("clr_state", state_dbg, ST_IDLE);
        tick(5);

        // clear and check together: check dropped
        check = 1'b1;
        clear = 1'b1;
        tick(1);
        check = 1'b0;
        clear = 1'b0;
        check_eq("clrchk_busy", busy, 0);
        check_eq("clrchk_state", state_dbg, ST_IDLE);
        tick(4);

        // Reset in the middle of FINE with crash set
        set_full_miss();
        obstacle_box[0] = mk_box(15, 6, 5, 3);
        run_check(8, 1'b1, 1, 0);
        set_full_miss();
        start_check(1'b0, 0, 1'b0, 0, 0);
        tick(4);
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_crash", crash, 0);
        check_eq("arst_hit_trex_idx", hit_trex_idx, 0);
        check_eq("arst_hit_obs_idx", hit_obs_idx, 0);
        model_clear();
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Random geometry against the reference model
        for (int r = 0; r < 24; r++) begin
            if (r % 8 == 7) begin
                clear = 1'b1;
                tick(1);
                clear = 1'b0;
                model_clear();
                tick(1);
            end
            randomize_geom();
            model(lat, hit, hi, hj);
            run_check(lat, hit, hi, hj);
        end
        obstacle_valid = 1'b1;
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
